// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared forwarding select codes and tracker layout
package rv_pipe_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;
   localparam logic [1:0] FWD_WBLAT = 2'b11;

   // Tracker slots, youngest first; each slot is {valid, we, is_load} flags plus rd.
   localparam int TRK_DEPTH  = 3;
   localparam int TRK_EX     = 0;
   localparam int TRK_MEM    = 1;
   localparam int TRK_WB     = 2;
   localparam int TRK_FLAG_W = 3;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - ID-stage request and EX-stage select bundle
interface fwd_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_rd_we;
   logic                  id_is_load;
   logic                  pipe_hold;
   logic                  flush;
   logic [1:0]            ex_fwd_sel_a;
   logic [1:0]            ex_fwd_sel_b;
   logic                  stall;
   logic                  ex_bubble;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output id_rd, id_rd_we, id_is_load, pipe_hold, flush,
      input  ex_fwd_sel_a, ex_fwd_sel_b, stall, ex_bubble
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  id_rd, id_rd_we, id_is_load, pipe_hold, flush,
      output ex_fwd_sel_a, ex_fwd_sel_b, stall, ex_bubble
   );
endinterface

// File: rtl/fwd_sel_pick.sv
// rtl/fwd_sel_pick.sv - youngest-first operand source pick for one operand
module fwd_sel_pick
   import rv_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter bit WB_BYPASS  = 1'b1
) (
   input  logic [REG_ADDR_W-1:0]                rs,
   input  logic                                 rs_used,
   input  logic [TRK_DEPTH-1:0]                 ent_valid,
   input  logic [TRK_DEPTH-1:0]                 ent_we,
   input  logic [TRK_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd,
   input  logic                                 ex_is_load,
   output logic [1:0]                           sel,
   output logic                                 load_hit
);

   logic [TRK_DEPTH-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < TRK_DEPTH; i++) begin
         hit[i] = ent_valid[i] & ent_we[i] & (ent_rd[i] == rs) & (rs != '0) & rs_used;
      end
   end

   // Without WB bypass the regfile is write-through, so a WB-only hit reads the regfile.
   always_comb begin
      sel = FWD_RF;
      if (hit[TRK_EX]) begin
         sel = FWD_EXMEM;
      end else if (hit[TRK_MEM]) begin
         sel = FWD_MEMWB;
      end else if (hit[TRK_WB] && WB_BYPASS) begin
         sel = FWD_WBLAT;
      end
   end

   assign load_hit = hit[TRK_EX] & ex_is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects and load-use stall control
module fwd_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter bit WB_BYPASS  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   fwd_hazard_ctrl_if.slave  bus
);

   logic [TRK_DEPTH-1:0]                 trk_valid_q, trk_valid_d;
   logic [TRK_DEPTH-1:0]                 trk_we_q, trk_we_d;
   logic [TRK_DEPTH-1:0]                 trk_load_q, trk_load_d;
   logic [TRK_DEPTH-1:0][REG_ADDR_W-1:0] trk_rd_q, trk_rd_d;
   logic [1:0]                           sel_a_q, sel_a_d;
   logic [1:0]                           sel_b_q, sel_b_d;
   logic                                 bubble_q, bubble_d;

   logic [1:0] pick_a, pick_b;
   logic       hit_a, hit_b;
   logic       stall, kill;

   fwd_sel_pick #(.REG_ADDR_W(REG_ADDR_W), .WB_BYPASS(WB_BYPASS)) u_pick_a (
      .rs(bus.id_rs1), .rs_used(bus.id_rs1_used),
      .ent_valid(trk_valid_q), .ent_we(trk_we_q), .ent_rd(trk_rd_q),
      .ex_is_load(trk_load_q[TRK_EX]), .sel(pick_a), .load_hit(hit_a)
   );

   fwd_sel_pick #(.REG_ADDR_W(REG_ADDR_W), .WB_BYPASS(WB_BYPASS)) u_pick_b (
      .rs(bus.id_rs2), .rs_used(bus.id_rs2_used),
      .ent_valid(trk_valid_q), .ent_we(trk_we_q), .ent_rd(trk_rd_q),
      .ex_is_load(trk_load_q[TRK_EX]), .sel(pick_b), .load_hit(hit_b)
   );

   // A stalled, flushed or empty ID slot becomes a bubble in EX; hold freezes everything.
   always_comb begin
      stall       = bus.id_valid & (hit_a | hit_b) & ~bus.flush & ~bus.pipe_hold;
      kill        = stall | bus.flush | ~bus.id_valid;
      trk_valid_d = trk_valid_q;
      trk_we_d    = trk_we_q;
      trk_load_d  = trk_load_q;
      trk_rd_d    = trk_rd_q;
      sel_a_d     = sel_a_q;
      sel_b_d     = sel_b_q;
      bubble_d    = bubble_q;
      if (!bus.pipe_hold) begin
         trk_valid_d = {trk_valid_q[TRK_DEPTH-2:0], ~kill};
         trk_we_d    = {trk_we_q[TRK_DEPTH-2:0], bus.id_rd_we};
         trk_load_d  = {trk_load_q[TRK_DEPTH-2:0], bus.id_is_load};
         trk_rd_d    = {trk_rd_q[TRK_DEPTH-2:0], bus.id_rd};
         sel_a_d     = kill ? FWD_RF : pick_a;
         sel_b_d     = kill ? FWD_RF : pick_b;
         bubble_d    = kill;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trk_valid_q <= '0;
         trk_we_q    <= '0;
         trk_load_q  <= '0;
         trk_rd_q    <= '0;
         sel_a_q     <= FWD_RF;
         sel_b_q     <= FWD_RF;
         bubble_q    <= 1'b1;
      end else begin
         trk_valid_q <= trk_valid_d;
         trk_we_q    <= trk_we_d;
         trk_load_q  <= trk_load_d;
         trk_rd_q    <= trk_rd_d;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         bubble_q    <= bubble_d;
      end
   end

   assign bus.ex_fwd_sel_a = sel_a_q;
   assign bus.ex_fwd_sel_b = sel_b_q;
   assign bus.ex_bubble    = bubble_q;
   assign bus.stall        = stall;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - bench for fwd_hazard_ctrl with and without WB bypass
module tb_fwd_hazard_ctrl;
   localparam int W = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         id_valid = 1'b0, u1 = 1'b0, u2 = 1'b0, rd_we = 1'b0, is_load = 1'b0;
   logic         hold = 1'b0, flush = 1'b0;
   logic [W-1:0] rs1 = '0, rs2 = '0, rd = '0;

   fwd_hazard_ctrl_if #(.REG_ADDR_W(W)) if1 ();
   fwd_hazard_ctrl_if #(.REG_ADDR_W(W)) if0 ();

   assign if1.id_valid = id_valid;    assign if0.id_valid = id_valid;
   assign if1.id_rs1 = rs1;           assign if0.id_rs1 = rs1;
   assign if1.id_rs2 = rs2;           assign if0.id_rs2 = rs2;
   assign if1.id_rs1_used = u1;       assign if0.id_rs1_used = u1;
   assign if1.id_rs2_used = u2;       assign if0.id_rs2_used = u2;
   assign if1.id_rd = rd;             assign if0.id_rd = rd;
   assign if1.id_rd_we = rd_we;       assign if0.id_rd_we = rd_we;
   assign if1.id_is_load = is_load;   assign if0.id_is_load = is_load;
   assign if1.pipe_hold = hold;       assign if0.pipe_hold = hold;
   assign if1.flush = flush;          assign if0.flush = flush;

   fwd_hazard_ctrl #(.REG_ADDR_W(W), .WB_BYPASS(1'b1)) dut_byp (.clk(clk), .rst_n(rst_n), .bus(if1));
   fwd_hazard_ctrl #(.REG_ADDR_W(W), .WB_BYPASS(1'b0)) dut_nob (.clk(clk), .rst_n(rst_n), .bus(if0));

   // In-flight instructions, index = age in stages past ID (0 = EX).
   typedef struct {bit valid; int rd; bit we; bit ld;} rec_t;
   rec_t inflight[$];
   int   exp_a1 = 0, exp_b1 = 0, exp_a0 = 0, exp_b0 = 0;
   bit   exp_bub = 1'b1;
   bit   m_kill;
   bit   chk_en = 1'b0;
   int   n_checks = 0, n_fail = 0;

   function automatic int model_sel(int rs, bit used, bit byp);
      for (int age = 0; age < inflight.size(); age++) begin
         if (inflight[age].valid && inflight[age].we && inflight[age].rd == rs && rs != 0 && used)
            return (age == 2 && !byp) ? 0 : age + 1;
      end
      return 0;
   endfunction

   function automatic bit model_stall();
      if (!id_valid || flush || hold || inflight.size() == 0) return 1'b0;
      if (!(inflight[0].valid && inflight[0].ld)) return 1'b0;
      return model_sel(int'(rs1), u1, 1'b1) == 1 || model_sel(int'(rs2), u2, 1'b1) == 1;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         inflight.delete();
         repeat (3) inflight.push_back('{valid: 1'b0, rd: 0, we: 1'b0, ld: 1'b0});
         exp_a1 = 0; exp_b1 = 0; exp_a0 = 0; exp_b0 = 0;
         exp_bub = 1'b1;
      end else if (!hold) begin
         m_kill  = model_stall() || flush || !id_valid;
         exp_a1  = m_kill ? 0 : model_sel(int'(rs1), u1, 1'b1);
         exp_b1  = m_kill ? 0 : model_sel(int'(rs2), u2, 1'b1);
         exp_a0  = m_kill ? 0 : model_sel(int'(rs1), u1, 1'b0);
         exp_b0  = m_kill ? 0 : model_sel(int'(rs2), u2, 1'b0);
         exp_bub = m_kill;
         inflight.push_front('{valid: !m_kill, rd: int'(rd), we: rd_we, ld: is_load});
         void'(inflight.pop_back());
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_sel_a_byp", int'(if1.ex_fwd_sel_a), exp_a1);
         check("cyc_sel_b_byp", int'(if1.ex_fwd_sel_b), exp_b1);
         check("cyc_sel_a_nob", int'(if0.ex_fwd_sel_a), exp_a0);
         check("cyc_sel_b_nob", int'(if0.ex_fwd_sel_b), exp_b0);
         check("cyc_bubble_byp", int'(if1.ex_bubble), int'(exp_bub));
         check("cyc_bubble_nob", int'(if0.ex_bubble), int'(exp_bub));
         check("cyc_stall_byp", int'(if1.stall), int'(model_stall()));
         check("cyc_stall_nob", int'(if0.stall), int'(model_stall()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(bit v, int a, bit ua, int b, bit ub, int d, bit we, bit ld);
      id_valid = v; rs1 = W'(a); u1 = ua; rs2 = W'(b); u2 = ub;
      rd = W'(d); rd_we = we; is_load = ld;
   endtask

   task automatic nop();
      set_id(1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic lit(string name, int sa1, int sb1, int sa0, int sb0, int bub);
      check({name, "_sel_a"}, int'(if1.ex_fwd_sel_a), sa1);
      check({name, "_sel_b"}, int'(if1.ex_fwd_sel_b), sb1);
      check({name, "_sel_a_nob"}, int'(if0.ex_fwd_sel_a), sa0);
      check({name, "_sel_b_nob"}, int'(if0.ex_fwd_sel_b), sb0);
      check({name, "_bubble"}, int'(if1.ex_bubble), bub);
   endtask

   initial begin
      step();
      chk_en = 1'b1;
      step();
      lit("reset", 0, 0, 0, 0, 1);
      check("reset_stall", int'(if1.stall), 0);
      rst_n = 1'b1;

      // back-to-back EX/MEM forward
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0); step();
      set_id(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0); #1;
      check("t1_stall", int'(if1.stall), 0);
      step();
      lit("t1", 1, 0, 1, 0, 0);

      // MEM/WB forward, then WB latch vs write-through regfile
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0); step();
      nop(); step();
      set_id(1'b1, 3, 1'b0, 7, 1'b1, 10, 1'b1, 1'b0); step();
      lit("t2_one_nop", 0, 2, 0, 2, 0);
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0); step();
      nop(); step();
      nop(); step();
      set_id(1'b1, 3, 1'b0, 7, 1'b1, 10, 1'b1, 1'b0); step();
      lit("t2_two_nop", 0, 3, 0, 0, 0);

      // load-use stall
      set_id(1'b1, 2, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1); step();
      set_id(1'b1, 8, 1'b1, 8, 1'b1, 9, 1'b1, 1'b0); #1;
      check("t3_stall", int'(if1.stall), 1);
      step();
      lit("t3_bubble", 0, 0, 0, 0, 1);
      check("t3_stall_gone", int'(if1.stall), 0);
      step();
      lit("t3_fwd", 2, 2, 2, 2, 0);

      // x0 never forwarded; youngest writer wins
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0); step();
      set_id(1'b1, 0, 1'b1, 0, 1'b1, 11, 1'b1, 1'b0); step();
      lit("t4_x0", 0, 0, 0, 0, 0);
      set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0); step();
      step();
      set_id(1'b1, 3, 1'b1, 3, 1'b1, 12, 1'b1, 1'b0); step();
      lit("t4_young", 1, 1, 1, 1, 0);

      // flush beats hazard, then hold freezes everything
      set_id(1'b1, 2, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1); step();
      set_id(1'b1, 8, 1'b1, 8, 1'b1, 9, 1'b1, 1'b0);
      flush = 1'b1; #1;
      check("t5_flush_stall", int'(if1.stall), 0);
      step();
      flush = 1'b0;
      lit("t5_flush", 0, 0, 0, 0, 1);
      hold = 1'b1; #1;
      check("t5_hold_stall", int'(if1.stall), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         lit("t5_hold", 0, 0, 0, 0, 1);
         check("t5_hold_stall_c", int'(if1.stall), 0);
      end
      hold = 1'b0;
      step();
      lit("t5_release", 2, 2, 2, 2, 0);

      // reset during a stall
      set_id(1'b1, 2, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1); step();
      set_id(1'b1, 8, 1'b1, 8, 1'b1, 9, 1'b1, 1'b0); #1;
      check("t6_stall", int'(if1.stall), 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      lit("t6_reset", 0, 0, 0, 0, 1);
      check("t6_stall_gone", int'(if1.stall), 0);
      step();
      lit("t6_regfile", 0, 0, 0, 0, 0);

      id_valid = 1'b0;
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
